// File: rtl/mem_pkg.sv
// Shared types and line-geometry constants for the I/D memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIFill,
        StDFill,
        StDWb
    } state_t;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LINE_OFF_W = $clog2(LINE_WORDS * WORD_BYTES);

    function automatic int unsigned line_bytes(input int unsigned words);
        return words * WORD_BYTES;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selection between I and D line requests, evaluated only while idle.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed D priority.
module mem_arb_sel (
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic idle,
    input  logic i_req,
    input  logic d_req,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    // Remembers which side won the previous grant so a tie goes to the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (gnt_i || gnt_d) begin
            last_d_q <= gnt_d;
        end
    end

    assign gnt_d = idle && d_req && (!i_req || !last_d_q);
`else
    assign gnt_d = idle && d_req;
`endif

    assign gnt_i = idle && i_req && !gnt_d;

endmodule

// File: rtl/mem_arb.sv
// Line-transfer arbiter between I-cache refills and D-cache refills/writebacks.
// Optional round-robin arbitration via MEM_ARB_RR_EN (see mem_arb_sel).
module mem_arb #(
    parameter int unsigned LINE_WORDS = mem_pkg::LINE_WORDS,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [31:0]                   d_wb_data,
    output logic                          d_done,
    output logic                          fill_vld,
    output logic                          fill_sel,
    output logic [31:0]                   fill_data,
    output logic [$clog2(LINE_WORDS)-1:0] xfer_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ack
);

    import mem_pkg::*;

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(line_bytes(LINE_WORDS) - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              idle, ack, last_ack, is_fill;
    logic              gnt_i, gnt_d;

    assign idle     = (state_q == StIdle);
    assign ack      = !idle && mem_ack;
    assign last_ack = ack && (idx_q == LAST_IDX);
    assign is_fill  = (state_q == StIFill) || (state_q == StDFill);

    // The side whose done is pulsing still holds its request this cycle; mask it
    // so the other side gets the slot after exactly one idle cycle.
    mem_arb_sel u_sel (
`ifdef MEM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .idle  (idle),
        .i_req (i_req && !i_done_q),
        .d_req (d_req && !d_done_q),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (gnt_d) begin
                    state_d = d_we ? StDWb : StDFill;
                    base_d  = d_addr & ~OFF_MASK;
                end else if (gnt_i) begin
                    state_d = StIFill;
                    base_d  = i_addr & ~OFF_MASK;
                end
            end
            default: begin
                if (ack) begin
                    idx_d = idx_q + 1'b1;
                end
                if (last_ack) begin
                    state_d  = StIdle;
                    i_done_d = (state_q == StIFill);
                    d_done_d = (state_q != StIFill);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            base_q   <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign xfer_idx  = idx_q;
    assign mem_req   = !idle;
    assign mem_we    = (state_q == StDWb);
    assign mem_addr  = base_q + ADDR_W'({idx_q, 2'b00});
    // Data buses are held at zero outside their owning state so reset drives them low.
    assign mem_wdata = mem_we ? d_wb_data : 32'h0;
    assign fill_vld  = ack && is_fill;
    assign fill_sel  = (state_q == StDFill);
    assign fill_data = fill_vld ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table of line transfers plus a scoreboard
// of expected words, and a hand-written mid-transfer reset sequence.
module tb_mem_arb;

    localparam logic [1:0] K_I    = 2'b00;
    localparam logic [1:0] K_DF   = 2'b01;
    localparam logic [1:0] K_DWB  = 2'b10;
    localparam logic [1:0] K_NONE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wb_data, mem_rdata;
    logic        i_done, d_done, fill_vld, fill_sel, mem_req, mem_we;
    logic [31:0] fill_data, mem_addr, mem_wdata;
    logic [3:0]  xfer_idx;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit          i_on;
        bit          d_on;
        bit          we;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        int          gap;
        bit          drop;
        logic [1:0]  kind0;
        logic [1:0]  kind1;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [31:0] wbpat(input int w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    assign mem_rdata = memfn(mem_addr);

    mem_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wb_data (d_wb_data),
        .d_done    (d_done),
        .fill_vld  (fill_vld),
        .fill_sel  (fill_sel),
        .fill_data (fill_data),
        .xfer_idx  (xfer_idx),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_line(input logic [1:0] kind, input logic [31:0] addr);
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            e.kind = kind;
            e.addr = (addr & ~32'h3F) + 32'(j * 4);
            e.idx  = 4'(j);
            e.data = (kind == K_DWB) ? wbpat(j) : memfn(e.addr);
            sb.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] k;
        exp_t       e;
        int         w;
        int         cyc;
        bit         ack;
        @(negedge clk);
        i_req  = v.i_on;
        i_addr = v.iaddr;
        d_req  = v.d_on;
        d_we   = v.we;
        d_addr = v.daddr;
        push_line(v.kind0, v.kind0 == K_I ? v.iaddr : v.daddr);
        if (v.kind1 != K_NONE) push_line(v.kind1, v.kind1 == K_I ? v.iaddr : v.daddr);
        for (int t = 0; t < 2; t++) begin
            k = (t == 0) ? v.kind0 : v.kind1;
            if (k == K_NONE) break;
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check("grant_req", 32'(mem_req), 32'd1);
            check("grant_kind", 32'({mem_we, fill_sel}), 32'(k));
            w   = 0;
            cyc = 0;
            while (w < 16 && cyc < 200) begin
                ack       = (cyc % (v.gap + 1)) == v.gap;
                mem_ack   = ack;
                d_wb_data = wbpat(w);
                #1;
                e = sb[0];
                check("mem_addr", mem_addr, e.addr);
                check("xfer_idx", 32'(xfer_idx), 32'(e.idx));
                check("mem_we", 32'(mem_we), 32'(k == K_DWB));
                if (ack) begin
                    void'(sb.pop_front());
                    check("fill_vld", 32'(fill_vld), 32'(k != K_DWB));
                    if (k == K_DWB) check("mem_wdata", mem_wdata, e.data);
                    else begin
                        check("fill_data", fill_data, e.data);
                        check("fill_sel", 32'(fill_sel), 32'(k == K_DF));
                    end
                    w++;
                end else begin
                    check("fill_vld_stall", 32'(fill_vld), 32'd0);
                end
                // Addresses and d_we change mid-transfer; the latched values must win.
                if (w == 5) begin
                    if (k == K_I) i_addr = 32'hDEAD_BEEF;
                    else begin
                        d_addr = 32'hDEAD_BEEF;
                        d_we   = ~d_we;
                    end
                end
                if (w == 8 && v.drop) begin
                    if (k == K_I) i_req = 1'b0;
                    else d_req = 1'b0;
                end
                cyc++;
                @(posedge clk);
                @(negedge clk);
            end
            if (w < 16) check("xfer_timeout", 32'(w), 32'd16);
            mem_ack = 1'b1;  // an ack while idle must be ignored
            #1;
            check("done", 32'({i_done, d_done}), (k == K_I) ? 32'h2 : 32'h1);
            check("idle_req", 32'(mem_req), 32'd0);
            check("idle_fill_vld", 32'(fill_vld), 32'd0);
            if (k == K_I) i_req = 1'b0;
            else d_req = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("final_idle", 32'(mem_req), 32'd0);
        check("final_done", 32'({i_done, d_done}), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 32'h0000_1234, 32'h0,         0, 1, K_I,   K_NONE};
        vecs[1] = '{0, 1, 1, 32'h0,         32'h0000_0040, 0, 0, K_DWB, K_NONE};
        vecs[2] = '{0, 1, 0, 32'h0,         32'h2468_ACF0, 2, 1, K_DF,  K_NONE};
        vecs[3] = '{1, 1, 0, 32'h0000_5678, 32'h0000_9ABC, 0, 0, K_DF,  K_I};
        vecs[4] = '{1, 1, 1, 32'h0001_0004, 32'h0002_00FF, 1, 0, K_DWB, K_I};
        vecs[5] = '{1, 0, 0, 32'hFFFF_FFFF, 32'h0,         1, 0, K_I,   K_NONE};

        rst_n     = 1'b0;
        i_req     = 1'b1;
        d_req     = 1'b1;
        d_we      = 1'b1;
        i_addr    = 32'h0000_1234;
        d_addr    = 32'h0000_0040;
        d_wb_data = 32'hFFFF_FFFF;
        mem_ack   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_fill_vld", 32'(fill_vld), 32'd0);
        check("rst_fill_data", fill_data, 32'd0);
        check("rst_xfer_idx", 32'(xfer_idx), 32'd0);
        check("rst_done", 32'({i_done, d_done}), 32'd0);
        @(negedge clk);
        i_req   = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'b0;
        rst_n   = 1'b1;

        for (int n = 0; n < 6; n++) run_vec(vecs[n]);

        // Reset at word 7 of an I refill: abandon with no done, then restart at word 0.
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 7; w++) begin
            mem_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("pre_rst_idx", 32'(xfer_idx), 32'd7);
        check("pre_rst_addr", mem_addr, 32'h0000_121C);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_idx", 32'(xfer_idx), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_fill_vld", 32'(fill_vld), 32'd0);
        check("mid_rst_fill_data", fill_data, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", 32'({i_done, d_done}), 32'd0);
            check("post_rst_req", 32'(mem_req), 32'd0);
        end
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
